imem_fetch_port: RTL

//  Parametrised instruction memory with a registered, back-pressurable fetch port.

---
 rtl/imem_fetch_port.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/imem_fetch_port.sv
// ---------------------------------------------------------------------------
// imem_fetch_port
// Instruction memory with a registered, back-pressurable fetch port.
// The memory is byte-addressed and word-organised, and holds little-endian
// 32-bit instructions. A separate program-load port writes whole words.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  cycles from fetch accept to rsp_valid when nothing stalls (1..4)
//   AW       word-index width, derived from DEPTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   req_valid  fetch request valid
//   req_ready  fetch request accepted when req_valid & req_ready
//   req_addr   byte address of the instruction
//   rsp_valid  response valid
//   rsp_ready  consumer takes the response when rsp_valid & rsp_ready
//   rsp_data   instruction word, 0 on any fault
//   rsp_err    00 ok, 01 misaligned, 10 out of range, 11 parity
//   ld_en      program-load write strobe (has priority over fetch)
//   ld_addr    word index to write
//   ld_data    word to write
//
// Optional feature (macro IMEM_PARITY_EN)
//   Stores one even-parity bit per word, computed on load and checked on read.
//   A mismatch on an otherwise clean fetch reports err 11 with data 0.
//   Without the macro there is no parity storage and err 11 never appears.
// ---------------------------------------------------------------------------
module imem_fetch_port #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic [1:0]    rsp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    localparam logic [1:0]  ERR_OK       = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_RANGE    = 2'b10;
`ifdef IMEM_PARITY_EN
    localparam logic [1:0]  ERR_PARITY   = 2'b11;
`endif
    // First byte address past the end of the array; 33 bits so that a
    // full 4 GiB memory would not wrap to zero.
    localparam logic [32:0] ADDR_LIMIT   = 33'(DEPTH) * 33'd4;

    logic [31:0]   mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
    logic          par_q [DEPTH];
    logic          parityBad;
`endif

    logic          validPipe_q [LATENCY];
    logic [31:0]   dataPipe_q  [LATENCY];
    logic [1:0]    errPipe_q   [LATENCY];

    logic          advance;
    logic          accept;
    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord;
    logic          outOfRange;
    logic          s1Valid_d;
    logic [31:0]   s1Data_d;
    logic [1:0]    s1Err_d;

    // The last stage drives the response directly, so every rsp_* output
    // comes straight from a flop.
    assign rsp_valid = validPipe_q[LATENCY-1];
    assign rsp_data  = dataPipe_q[LATENCY-1];
    assign rsp_err   = errPipe_q[LATENCY-1];

    // The whole pipeline moves as one unit: it shifts only when the output
    // slot is empty or being drained. A load takes the cycle away from
    // fetch, and nothing is accepted while reset is held.
    assign advance   = !rsp_valid || rsp_ready;
    assign req_ready = rst_n && advance && !ld_en;
    assign accept    = req_valid && req_ready;

    // Memory array writes. The array is not reset, and a load proceeds
    // even while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
            par_q[ld_addr] <= ^ld_data;
`endif
        end
    end

    // Build the s1 entry. Fault priority is misaligned, then out of range,
    // then parity. Any fault zeroes the data. A cycle that advances without
    // an accept inserts a zeroed bubble.
    always_comb begin
        wordIdx    = req_addr[AW+1:2];
        rdWord     = mem_q[wordIdx];
        outOfRange = ({1'b0, req_addr} >= ADDR_LIMIT);
`ifdef IMEM_PARITY_EN
        parityBad  = ((^rdWord) != par_q[wordIdx]);
`endif
        s1Valid_d  = accept;
        s1Data_d   = '0;
        s1Err_d    = ERR_OK;
        if (accept) begin
            if (req_addr[1:0] != 2'b00) begin
                s1Err_d = ERR_MISALIGN;
            end else if (outOfRange) begin
                s1Err_d = ERR_RANGE;
`ifdef IMEM_PARITY_EN
            end else if (parityBad) begin
                s1Err_d = ERR_PARITY;
`endif
            end else begin
                s1Data_d = rdWord;
            end
        end
    end

    // Read pipeline. Reset clears everything in flight. A stall holds every
    // stage, so reads already captured are unaffected by later loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                validPipe_q[i] <= 1'b0;
                dataPipe_q[i]  <= '0;
                errPipe_q[i]   <= ERR_OK;
            end
        end else if (advance) begin
            validPipe_q[0] <= s1Valid_d;
            dataPipe_q[0]  <= s1Data_d;
            errPipe_q[0]   <= s1Err_d;
            for (int i = 1; i < LATENCY; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
                dataPipe_q[i]  <= dataPipe_q[i-1];
                errPipe_q[i]   <= errPipe_q[i-1];
            end
        end
    end

endmodule
